// File: rtl/iq_fifo_burst_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// iq_fifo_burst_scheduler_pkg
// Shared definitions for the IQ FIFO burst scheduler: scheduler state
// encoding, channel index constants and a saturating counter helper.
// No ports (package).
// ----------------------------------------------------------------------------
package iq_fifo_burst_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Channel indices: sub-GHz RX and 2.4 GHz RX.
  localparam logic CH_09 = 1'b0;
  localparam logic CH_24 = 1'b1;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/iq_fifo_burst_scheduler_rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter. When both request, the grant goes to the
// requester that was not served last. The last-served register resets to
// CH_24 so that CH_09 wins the first contested arbitration.
// Ports:
//   clk_i, rst_b_i : clock, synchronous active-low reset
//   req_i[1:0]     : request per channel
//   upd_i          : record upd_ch_i as last-served on this edge
//   upd_ch_i       : channel that has just finished being served
//   gnt_valid_o    : at least one request present
//   gnt_ch_o       : granted channel (meaningful when gnt_valid_o)
// ----------------------------------------------------------------------------
module rr_arbiter2
  import iq_fifo_burst_scheduler_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_b_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_ch_i,
  output logic       gnt_valid_o,
  output logic       gnt_ch_o
);

  logic last_q;
  logic last_d;

  // Next value of the last-served register.
  always_comb begin
    last_d = last_q;
    if (upd_i) begin
      last_d = upd_ch_i;
    end else begin
      last_d = last_q;
    end
  end

  // Last-served register.
  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      last_q <= CH_24;
    end else begin
      last_q <= last_d;
    end
  end

  // Grant selection; contested requests favour the channel not served last.
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_ch_o    = CH_09;
    case (req_i)
      2'b01:   gnt_ch_o = CH_09;
      2'b10:   gnt_ch_o = CH_24;
      2'b11:   gnt_ch_o = ~last_q;
      default: gnt_ch_o = CH_09;
    endcase
  end

endmodule

// File: rtl/iq_fifo_burst_scheduler.sv
// ----------------------------------------------------------------------------
// iq_fifo_burst_scheduler
// Drains two FWFT sample FIFOs (CH_09 sub-GHz, CH_24 2.4 GHz) into one tagged
// output stream, round-robin in bursts of BURST_LEN words, with one idle
// cycle between pops. A burst on an empty FIFO is abandoned after
// STARVE_CYCLES consecutive empty cycles.
// Ports:
//   clk_i, rst_b_i           : read clock, synchronous active-low reset
//   ch_en_i[1:0]             : per-channel enable
//   chN_data_i, chN_empty_i  : FIFO N head word and empty flag
//   chN_rd_en_o              : FIFO N pop strobe (combinational)
//   out_data_o/out_valid_o/out_ready_i/out_ch_o/out_sof_o : output stream
//   starve_cnt_o             : abandoned burst count, saturating
//   busy_o                   : scheduler not in IDLE
// ----------------------------------------------------------------------------
module iq_fifo_burst_scheduler
  import iq_fifo_burst_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int BURST_LEN     = 256,
  parameter int STARVE_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_b_i,
  input  logic [1:0]            ch_en_i,
  input  logic [DATA_WIDTH-1:0] ch0_data_i,
  input  logic [DATA_WIDTH-1:0] ch1_data_i,
  input  logic                  ch0_empty_i,
  input  logic                  ch1_empty_i,
  output logic                  ch0_rd_en_o,
  output logic                  ch1_rd_en_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_ch_o,
  output logic                  out_sof_o,
  output logic [15:0]           starve_cnt_o,
  output logic                  busy_o
);

  // One extra bit so the terminal values themselves are representable.
  localparam int WCW = $clog2(BURST_LEN) + 1;
  localparam int SCW = $clog2(STARVE_CYCLES) + 1;
  localparam logic [WCW-1:0] BURST_W  = WCW'(BURST_LEN);
  localparam logic [SCW-1:0] STARVE_W = SCW'(STARVE_CYCLES);

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [SCW-1:0]        starve_q, starve_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_ch_q, out_ch_d;
  logic                  out_sof_q, out_sof_d;
  logic [15:0]           starve_cnt_q, starve_cnt_d;

  logic                  slot_free;
  logic                  g_en;
  logic                  g_empty;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  pop;
  logic                  rec;
  logic                  arb_valid;
  logic                  arb_ch;
  logic [SCW-1:0]        starve_inc;
  logic [1:0]            req;

  assign req = ch_en_i & {~ch1_empty_i, ~ch0_empty_i};

  rr_arbiter2 u_arb (
    .clk_i      (clk_i),
    .rst_b_i    (rst_b_i),
    .req_i      (req),
    .upd_i      (rec),
    .upd_ch_i   (grant_q),
    .gnt_valid_o(arb_valid),
    .gnt_ch_o   (arb_ch)
  );

  // Granted-channel view and pop decision; no dependence on out_data_q.
  always_comb begin
    slot_free = ~out_valid_q | out_ready_i;
    g_en      = ch_en_i[grant_q];
    if (grant_q == CH_24) begin
      g_empty = ch1_empty_i;
      g_data  = ch1_data_i;
    end else begin
      g_empty = ch0_empty_i;
      g_data  = ch0_data_i;
    end
    pop = (state_q == XFER) & g_en & slot_free & ~g_empty;
  end

  assign ch0_rd_en_o = pop & (grant_q == CH_09);
  assign ch1_rd_en_o = pop & (grant_q == CH_24);

  // Next-state and output-register logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    word_cnt_d   = word_cnt_q;
    starve_d     = starve_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_sof_d    = out_sof_q;
    starve_cnt_d = starve_cnt_q;
    rec          = 1'b0;
    starve_inc   = starve_q + {{(SCW-1){1'b0}}, 1'b1};

    // A pending word survives everything except its own acceptance.
    if (pop) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d    = arb_ch;
          word_cnt_d = '0;
          starve_d   = '0;
          state_d    = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (!g_en) begin
          rec     = 1'b1;
          state_d = IDLE;
        end else if (!slot_free) begin
          state_d = XFER;
        end else if (!g_empty) begin
          out_data_d = g_data;
          out_ch_d   = grant_q;
          out_sof_d  = (word_cnt_q == '0);
          word_cnt_d = word_cnt_q + {{(WCW-1){1'b0}}, 1'b1};
          starve_d   = '0;
          state_d    = GAP;
        end else begin
          starve_d = starve_inc;
          if (starve_inc == STARVE_W) begin
            starve_cnt_d = sat_inc16(starve_cnt_q);
            rec          = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = XFER;
          end
        end
      end
      GAP: begin
        if ((word_cnt_q == BURST_W) || !g_en) begin
          rec     = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = XFER;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      state_q      <= IDLE;
      grant_q      <= CH_09;
      word_cnt_q   <= '0;
      starve_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= 1'b0;
      out_sof_q    <= 1'b0;
      starve_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      word_cnt_q   <= word_cnt_d;
      starve_q     <= starve_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_sof_q    <= out_sof_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign out_ch_o     = out_ch_q;
  assign out_sof_o    = out_sof_q;
  assign starve_cnt_o = starve_cnt_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_iq_fifo_burst_scheduler.sv
// ----------------------------------------------------------------------------
// tb_iq_fifo_burst_scheduler
// Directed bench: two FWFT FIFO models built on queues, a scoreboard of
// expected output words, and per-cycle protocol checks.
// ----------------------------------------------------------------------------
module tb_iq_fifo_burst_scheduler;

  typedef struct packed {
    logic [15:0] data;
    logic        ch;
    logic        sof;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [1:0]  ch_en;
  logic [15:0] ch0_data, ch1_data;
  logic        ch0_empty, ch1_empty;
  logic        rd0, rd1;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_ch;
  logic        out_sof;
  logic [15:0] starve_cnt;
  logic        busy;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  exp_t        expq[$];
  exp_t        e;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_pop_cyc = -10;
  int last_rd0_cyc = -1;
  int sp2 = 0;
  int sp_other = 0;
  int pops0 = 0;
  bit pend0 = 1'b0;
  bit pend1 = 1'b0;
  bit mon_en = 1'b0;
  bit prev_hold = 1'b0;
  logic [15:0] prev_data;
  logic        prev_ch, prev_sof;

  iq_fifo_burst_scheduler dut (
    .clk_i       (clk),
    .rst_b_i     (rst_b),
    .ch_en_i     (ch_en),
    .ch0_data_i  (ch0_data),
    .ch1_data_i  (ch1_data),
    .ch0_empty_i (ch0_empty),
    .ch1_empty_i (ch1_empty),
    .ch0_rd_en_o (rd0),
    .ch1_rd_en_o (rd1),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ch_o    (out_ch),
    .out_sof_o   (out_sof),
    .starve_cnt_o(starve_cnt),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // FIFO models and stream monitor: pops take effect after the edge that
  // consumed them; DUT outputs are sampled 2 time units after the negedge.
  always @(negedge clk) begin
    if (pend0 && q0.size() > 0) void'(q0.pop_front());
    if (pend1 && q1.size() > 0) void'(q1.pop_front());
    ch0_empty = (q0.size() == 0);
    ch1_empty = (q1.size() == 0);
    ch0_data  = ch0_empty ? 16'h0000 : q0[0];
    ch1_data  = ch1_empty ? 16'h0000 : q1[0];
    cyc++;
    #2;
    if (mon_en) begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_ch", out_ch, prev_ch);
        check("hold_sof", out_sof, prev_sof);
      end
      if (rd0 === 1'b1 || rd1 === 1'b1) begin
        check("one_rd_en", rd0 & rd1, 0);
        check("no_back2back", (last_pop_cyc == cyc - 1), 0);
        check("pop_slot_free", out_valid & ~out_ready, 0);
        last_pop_cyc = cyc;
      end
      if (rd0 === 1'b1) begin
        if (last_rd0_cyc >= 0) begin
          if (cyc - last_rd0_cyc == 2) sp2++;
          else sp_other++;
        end
        last_rd0_cyc = cyc;
        pops0++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (expq.size() == 0) begin
          check("unexpected_word", out_data, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          check("word_data", out_data, e.data);
          check("word_ch", out_ch, e.ch);
          check("word_sof", out_sof, e.sof);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_ch   = out_ch;
      prev_sof  = out_sof;
    end
    pend0 = (rd0 === 1'b1);
    pend1 = (rd1 === 1'b1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_b  = 1'b0;
    mon_en = 1'b0;
    ch_en  = 2'b00;
    out_ready = 1'b1;
    step();
    step();
    q0.delete();
    q1.delete();
    expq.delete();
    prev_hold    = 1'b0;
    last_pop_cyc = -10;
    last_rd0_cyc = -1;
    sp2 = 0;
    sp_other = 0;
    pops0 = 0;
    rst_b  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((expq.size() != 0 || out_valid !== 1'b0) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) check("drain_timeout", expq.size(), 0);
  endtask

  initial begin
    int k;
    int idle_cyc;

    // Reset with both FIFOs non-empty and both channels enabled.
    rst_b = 1'b0;
    ch_en = 2'b11;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(16'hA000 + 16'(i));
      q1.push_back(16'hB000 + 16'(i));
    end
    repeat (3) begin
      step();
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_ch", out_ch, 0);
      check("rst_sof", out_sof, 0);
      check("rst_rd0", rd0, 0);
      check("rst_rd1", rd1, 0);
      check("rst_starve", starve_cnt, 0);
      check("rst_busy", busy, 0);
    end

    // Single channel, two full bursts.
    reset_dut();
    for (int i = 0; i < 512; i++) begin
      q0.push_back(16'(i));
      expq.push_back('{data: 16'(i), ch: 1'b0, sof: (i % 256 == 0)});
    end
    ch_en = 2'b01;
    wait_drain(2000);
    check("t1_spacing2", sp2, 510);
    check("t1_spacing_other", sp_other, 1);
    check("t1_starve", starve_cnt, 0);
    check("t1_busy", busy, 0);

    // Alternation between two full FIFOs.
    reset_dut();
    for (int i = 0; i < 512; i++) begin
      q0.push_back(16'h1000 + 16'(i));
      q1.push_back(16'h2000 + 16'(i));
    end
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 256; i++) begin
        expq.push_back('{data: (b[0] ? 16'h2000 : 16'h1000) + 16'((b / 2) * 256 + i),
                         ch: b[0], sof: (i == 0)});
      end
    end
    ch_en = 2'b11;
    wait_drain(4000);
    check("t2_fifo0_left", q0.size(), 0);
    check("t2_fifo1_left", q1.size(), 0);

    // Backpressure: consumer ready one cycle in three.
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      q0.push_back(16'h6000 + 16'(i));
      expq.push_back('{data: 16'h6000 + 16'(i), ch: 1'b0, sof: (i % 256 == 0)});
    end
    ch_en = 2'b01;
    k = 0;
    while ((expq.size() != 0 || out_valid !== 1'b0) && k < 3000) begin
      out_ready = (k % 3 == 0);
      step();
      k++;
    end
    if (k >= 3000) check("t3_timeout", expq.size(), 0);
    out_ready = 1'b1;
    check("t3_fifo0_left", q0.size(), 0);

    // Starvation: short FIFO0, then FIFO1 waiting behind it.
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(16'h3000 + 16'(i));
      expq.push_back('{data: 16'h3000 + 16'(i), ch: 1'b0, sof: (i == 0)});
    end
    ch_en = 2'b11;
    k = 0;
    while (expq.size() != 0 && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) check("t4_first_timeout", expq.size(), 0);
    for (int i = 0; i < 4; i++) begin
      q1.push_back(16'h4000 + 16'(i));
      expq.push_back('{data: 16'h4000 + 16'(i), ch: 1'b1, sof: (i == 0)});
    end
    k = 0;
    while (busy !== 1'b0 && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) check("t4_idle_timeout", busy, 0);
    idle_cyc = cyc;
    check("t4_starve_cycles", idle_cyc - last_pop_cyc, 66);
    check("t4_starve_cnt1", starve_cnt, 1);
    wait_drain(100);
    repeat (80) step();
    check("t4_starve_cnt2", starve_cnt, 2);
    check("t4_busy", busy, 0);

    // Disable mid-burst after word 5, with the consumer stalled.
    reset_dut();
    for (int i = 0; i < 20; i++) q0.push_back(16'h5000 + 16'(i));
    for (int i = 0; i < 6; i++) begin
      expq.push_back('{data: 16'h5000 + 16'(i), ch: 1'b0, sof: (i == 0)});
    end
    ch_en = 2'b01;
    k = 0;
    while (pops0 < 6 && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) check("t5_pop_timeout", pops0, 6);
    ch_en = 2'b00;
    out_ready = 1'b0;
    k = 0;
    while (busy !== 1'b0 && k < 2) begin
      step();
      k++;
    end
    check("t5_busy_low", busy, 0);
    repeat (3) step();
    check("t5_held_valid", out_valid, 1);
    check("t5_held_data", out_data, 16'h5005);
    out_ready = 1'b1;
    repeat (5) step();
    check("t5_delivered", expq.size(), 0);
    check("t5_pops", pops0, 6);
    check("t5_fifo0_left", q0.size(), 14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iq_fifo_burst_scheduler.md
# iq_fifo_burst_scheduler

Read-side scheduler that drains two first-word-fall-through sample FIFOs (channel 0: sub-GHz RX, channel 1: 2.4 GHz RX) into a single tagged output stream toward the host interface. It runs entirely in the FIFO read clock domain, arbitrates round-robin between enabled channels in fixed-length bursts, and enforces the FIFOs' one-idle-cycle-between-pops rule. Burst start is marked so the host can realign channel framing.

## Interface
- DATA_WIDTH, 16, sample word width; matches the FIFO read data width.
- BURST_LEN, 256, words per burst; power of two, at least 2, even (I/Q pairs).
- STARVE_CYCLES, 64, consecutive cycles with the active FIFO empty before a burst is abandoned.
- clk_i  in  1  read-side clock; all logic on the rising edge.
- rst_b_i  in  1  reset; synchronous, active-low.
- ch_en_i  in  2  per-channel enable; bit n enables channel n.
- ch0_data_i / ch1_data_i  in  DATA_WIDTH  FWFT head word of FIFO n.
- ch0_empty_i / ch1_empty_i  in  1  FIFO n empty.
- ch0_rd_en_o / ch1_rd_en_o  out  1  pop strobe to FIFO n.
- out_data_o  out  DATA_WIDTH  output word.
- out_valid_o  out  1  out_data_o holds a word.
- out_ready_i  in  1  consumer accepts the word when high with out_valid_o.
- out_ch_o  out  1  channel tag of out_data_o.
- out_sof_o  out  1  out_data_o is the first word of a burst.
- starve_cnt_o  out  16  count of abandoned bursts; saturates at 0xFFFF.
- busy_o  out  1  state other than IDLE.

## Operation
- States: IDLE, XFER, GAP.
- IDLE: candidate = enabled channel with !empty. If both qualify, grant goes to the channel not served last; last-served resets to 1, so channel 0 wins first. Grant loads word counter = 0 and starve counter = 0, then moves to XFER. Nothing qualifies: stay.
- XFER: "slot free" = !out_valid_o or out_ready_i. Slot free and granted FIFO !empty: pop. Pop drives rd_en_o of the granted channel only, loads out_data_o from that FIFO's data, sets out_valid_o, out_ch_o = grant, out_sof_o = (word counter == 0), increments word counter, clears starve counter, then moves to GAP.
- XFER, FIFO empty: increment starve counter. On reaching STARVE_CYCLES: increment starve_cnt_o (saturating), record last-served, then go to IDLE.
- XFER, slot not free: hold; starve counter unchanged.
- GAP: exactly one cycle with no pop. Next state:
  - word counter == BURST_LEN: record last-served, go to IDLE.
  - grant channel disabled: record last-served, go to IDLE.
  - otherwise: XFER.
- Disable while in XFER: no pop that cycle. Record last-served, go to IDLE.
- Disable does not drop a word already in the output register. The word is still presented until accepted.
- Output register: out_valid_o clears when out_ready_i is high and no new pop occurs that cycle. Data and tags hold stable while out_valid_o is high and out_ready_i is low.
- Widths: word counter is log2(BURST_LEN)+1 bits, so BURST_LEN itself is representable. Starve counter is log2(STARVE_CYCLES)+1 bits.

## Timing
- Reset values: out_valid_o 0, out_data_o 0, out_ch_o 0, out_sof_o 0, ch*_rd_en_o 0, starve_cnt_o 0, busy_o 0; state IDLE.
- Reset applies mid-burst with the same values and takes effect on the next edge.
- rd_en outputs are combinational from state, grant, empty and slot-free; no path from out_data_o.
- Latency from FIFO non-empty in IDLE to first output word valid: 2 cycles (grant edge, then pop edge).
- Peak throughput: 1 word per 2 cycles per burst.
- A burst of BURST_LEN words, never stalled, occupies 2*BURST_LEN+1 cycles including the grant cycle.
- No pop ever occurs on two consecutive cycles, on either channel.
- At most one rd_en output is high in any cycle.

## Structure
- Shared package: state enum (IDLE/XFER/GAP) and channel index constants CH_09 = 0, CH_24 = 1. The top-level stream mux reuses the package.
- One natural sub-module: rr_arbiter2, a two-requester round-robin with a last-served register. All else stays in one module.

## Test plan
- Reset: rst_b_i low for 3 cycles with both FIFOs non-empty -> all outputs 0, no rd_en pulse.
- Single channel: ch_en_i = 01, FIFO0 preloaded with 0x0000..0x01FF, out_ready_i = 1, BURST_LEN = 256 -> two bursts of 256 words, all out_ch_o = 0.
  - out_sof_o high on 0x0000 and 0x0100 only.
  - rd_en pulses exactly 2 cycles apart within a burst.
- Alternation: both enabled, both FIFOs full -> bursts alternate 0,1,0,1.
  - Every out_ch_o change coincides with out_sof_o.
  - Never both rd_en high.
- Backpressure: out_ready_i toggling 1-of-3 cycles -> no word lost or duplicated, words still in order.
  - out_data_o stable while out_valid_o && !out_ready_i.
  - No pop while the slot is not free.
- Starvation: FIFO0 holds 10 words, STARVE_CYCLES = 64 -> 10 words emitted.
  - 64 cycles later: starve_cnt_o = 1, state IDLE.
  - A pending FIFO1 is then granted.
- Disable mid-burst: clear ch_en_i[0] after word 5 -> word 5 still delivered, no further pops on channel 0, busy_o low within 2 cycles.
